sys_dma_ctrl: RTL and testbench

Block-copy engine that sits directly upstream of the systolic I/O buffer on its `ibus` port. It streams N 16-bit words from data memory into the A/B input buffers, or from the S output buffers back to data memory, at one word per cycle. It absorbs the fixed read latency of both sides with an in-flight pipeline and reports completion with a single-cycle pulse.

---
 rtl/sys_dma_pkg.sv | 18 +
 rtl/sys_dma_rdpipe.sv | 35 +++
 rtl/sys_dma_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sys_dma_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_dma_pkg.sv
// Shared types and constants for the sys_dma block-copy engine.
package sys_dma_pkg;

  localparam int unsigned ADR_W      = 14;
  localparam int unsigned LEN_W      = 11;
  localparam int unsigned RD_LAT_DEF = 2;

  localparam logic DIR_LOAD   = 1'b0;  // mem -> ibus
  localparam logic DIR_UNLOAD = 1'b1;  // ibus -> mem

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } dma_state_e;

endpackage

// File: rtl/sys_dma_rdpipe.sv
// In-flight read tracker: a DEPTH-deep delay line of valid bits.
//   clk, rst_n : clock, async active-low reset (clears all slots)
//   push_i     : a read is issued for the coming cycle
//   pop_o      : a read's data becomes valid next cycle
//   empty_o    : no read is in flight
module sys_dma_rdpipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  output logic pop_o,
  output logic empty_o
);

  logic [DEPTH-1:0] vld_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= push_i;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= {vld_q[DEPTH-2:0], push_i};
      end
    end
  endgenerate

  assign pop_o   = vld_q[DEPTH-1];
  assign empty_o = (vld_q == '0);

endmodule

// File: rtl/sys_dma_ctrl.sv
// Block-copy engine between data memory and the systolic I/O buffer.
// Copies cmd_len 16-bit words one per cycle, mem->ibus (load) or
// ibus->mem (unload), hiding RD_LAT cycles of read latency.
//   cmd_*        : command handshake (accepted only in IDLE)
//   busy/done    : progress, done is a one-cycle pulse
//   words_done   : destination writes issued for current/last command
//   ibus_* mem_* : read and write ports of the two sides
module sys_dma_ctrl
  import sys_dma_pkg::*;
#(
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [15:2] cmd_src,
  input  logic [15:2] cmd_dst,
  input  logic [10:0] cmd_len,
  output logic        busy,
  output logic        done,
  output logic [10:0] words_done,
  output logic        ibus_ren,
  output logic [15:2] ibus_radr,
  input  logic [15:0] ibus_rdata,
  output logic        ibus_wen,
  output logic [15:2] ibus_wadr,
  output logic [15:0] ibus_wdata,
  output logic        mem_ren,
  output logic [15:2] mem_radr,
  input  logic [15:0] mem_rdata,
  output logic        mem_wen,
  output logic [15:2] mem_wadr,
  output logic [15:0] mem_wdata
);

  dma_state_e       state_q;
  logic             dir_q;
  logic [ADR_W-1:0] radr_q;
  logic [ADR_W-1:0] dst_q;
  logic [ADR_W-1:0] wadr_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] wcnt_q;
  logic             ibus_ren_q, mem_ren_q;
  logic             ibus_wen_q, mem_wen_q;
  logic             done_q;
  logic             ready_q;

  logic rd_go_d;
  logic rd_dir_d;
  logic pop;
  logic pipe_empty;

  // Read for the coming cycle: either the first read of a newly accepted
  // command or a further read while reads remain.
  always_comb begin
    rd_go_d  = 1'b0;
    rd_dir_d = dir_q;
    if (state_q == IDLE) begin
      rd_go_d  = cmd_valid && (cmd_len != '0);
      rd_dir_d = cmd_dir;
    end else if (state_q == ISSUE) begin
      rd_go_d  = (cnt_q != LEN_W'(1));
    end
  end

  // Valid bit enters with the registered ren, so it leaves the line in the
  // cycle before the data arrives; the registered wen then lines up with it.
  sys_dma_rdpipe #(
    .DEPTH (RD_LAT)
  ) u_rdpipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_go_d),
    .pop_o   (pop),
    .empty_o (pipe_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dir_q      <= DIR_LOAD;
      radr_q     <= '0;
      dst_q      <= '0;
      wadr_q     <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      ibus_ren_q <= 1'b0;
      mem_ren_q  <= 1'b0;
      ibus_wen_q <= 1'b0;
      mem_wen_q  <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      done_q     <= 1'b0;
      ibus_ren_q <= rd_go_d && (rd_dir_d == DIR_UNLOAD);
      mem_ren_q  <= rd_go_d && (rd_dir_d == DIR_LOAD);
      ibus_wen_q <= pop && (dir_q == DIR_LOAD);
      mem_wen_q  <= pop && (dir_q == DIR_UNLOAD);
      if (pop) begin
        wadr_q <= dst_q + ADR_W'(wcnt_q);
        wcnt_q <= wcnt_q + LEN_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            dir_q   <= cmd_dir;
            radr_q  <= cmd_src;
            dst_q   <= cmd_dst;
            cnt_q   <= cmd_len;
            wcnt_q  <= '0;
            ready_q <= 1'b0;
            if (cmd_len != '0) begin
              state_q <= ISSUE;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (cnt_q == LEN_W'(1)) begin
            state_q <= DRAIN;
          end else begin
            cnt_q  <= cnt_q - LEN_W'(1);
            radr_q <= radr_q + ADR_W'(1);
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = ~ready_q;
  assign done       = done_q;
  assign words_done = wcnt_q;

  assign ibus_ren   = ibus_ren_q;
  assign ibus_radr  = radr_q;
  assign mem_ren    = mem_ren_q;
  assign mem_radr   = radr_q;

  // Write data is the source read data of the same cycle, forced to zero
  // when the port is not writing.
  assign ibus_wen   = ibus_wen_q;
  assign ibus_wadr  = wadr_q;
  assign ibus_wdata = ibus_wen_q ? mem_rdata : '0;
  assign mem_wen    = mem_wen_q;
  assign mem_wadr   = wadr_q;
  assign mem_wdata  = mem_wen_q ? ibus_rdata : '0;

endmodule

// File: tb/tb_sys_dma_ctrl.sv
module tb_sys_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:2] cmd_src;
  logic [15:2] cmd_dst;
  logic [10:0] cmd_len;
  logic        busy;
  logic        done;
  logic [10:0] words_done;
  logic        ibus_ren;
  logic [15:2] ibus_radr;
  logic [15:0] ibus_rdata;
  logic        ibus_wen;
  logic [15:2] ibus_wadr;
  logic [15:0] ibus_wdata;
  logic        mem_ren;
  logic [15:2] mem_radr;
  logic [15:0] mem_rdata;
  logic        mem_wen;
  logic [15:2] mem_wadr;
  logic [15:0] mem_wdata;

  int checks   = 0;
  int failures = 0;

  sys_dma_ctrl #(
    .RD_LAT (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .ibus_ren   (ibus_ren),
    .ibus_radr  (ibus_radr),
    .ibus_rdata (ibus_rdata),
    .ibus_wen   (ibus_wen),
    .ibus_wadr  (ibus_wadr),
    .ibus_wdata (ibus_wdata),
    .mem_ren    (mem_ren),
    .mem_radr   (mem_radr),
    .mem_rdata  (mem_rdata),
    .mem_wen    (mem_wen),
    .mem_wadr   (mem_wadr),
    .mem_wdata  (mem_wdata)
  );

  always #5 clk = ~clk;

  // Two-cycle read-latency models: mem returns 0xA000+addr, ibus 0x5000+addr.
  logic        m_v1 = 1'b0, m_v2 = 1'b0, i_v1 = 1'b0, i_v2 = 1'b0;
  logic [13:0] m_a1 = '0, m_a2 = '0, i_a1 = '0, i_a2 = '0;
  always @(posedge clk) begin
    m_v1 <= mem_ren;  m_a1 <= mem_radr;  m_v2 <= m_v1; m_a2 <= m_a1;
    i_v1 <= ibus_ren; i_a1 <= ibus_radr; i_v2 <= i_v1; i_a2 <= i_a1;
  end
  assign mem_rdata  = m_v2 ? (16'hA000 + {2'b00, m_a2}) : 16'hDEAD;
  assign ibus_rdata = i_v2 ? (16'h5000 + {2'b00, i_a2}) : 16'hDEAD;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, " ibus_ren"}, 32'(ibus_ren), 0);
    chk({tag, " mem_ren"},  32'(mem_ren),  0);
    chk({tag, " ibus_wen"}, 32'(ibus_wen), 0);
    chk({tag, " mem_wen"},  32'(mem_wen),  0);
  endtask

  // Issue one command from a ready cycle (cycle 0) and check every cycle up
  // to the first ready cycle afterwards. With hold=1 cmd_valid stays high.
  task automatic run_cmd(input logic dir, input logic [13:0] src,
                         input logic [13:0] dst, input int len, input bit hold);
    int          last;
    bit          rd, wr, dn;
    int          wd;
    logic [13:0] ra, wa;
    logic [15:0] wdat, base;
    string       t;
    cmd_dir   = dir;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = 11'(len);
    cmd_valid = 1'b1;
    chk("cycle0 cmd_ready", 32'(cmd_ready), 1);
    tick();
    if (!hold) cmd_valid = 1'b0;
    last = (len == 0) ? 2 : len + 4;
    base = (dir == 1'b0) ? 16'hA000 : 16'h5000;
    for (int k = 1; k <= last; k++) begin
      t    = $sformatf("d%0d s%0h n%0d c%0d", dir, src, len, k);
      rd   = (len != 0) && (k <= len);
      wr   = (len != 0) && (k >= 3) && (k <= len + 2);
      dn   = (len == 0) ? (k == 1) : (k == len + 3);
      wd   = (len == 0 || k < 3) ? 0 : ((k > len + 2) ? len : k - 2);
      ra   = src + 14'(k - 1);
      wa   = dst + 14'(k - 3);
      wdat = base + {2'b00, 14'(src + 14'(k - 3))};
      chk({t, " mem_ren"},    32'(mem_ren),    32'(rd && dir == 1'b0));
      chk({t, " ibus_ren"},   32'(ibus_ren),   32'(rd && dir == 1'b1));
      chk({t, " ibus_wen"},   32'(ibus_wen),   32'(wr && dir == 1'b0));
      chk({t, " mem_wen"},    32'(mem_wen),    32'(wr && dir == 1'b1));
      chk({t, " done"},       32'(done),       32'(dn));
      chk({t, " cmd_ready"},  32'(cmd_ready),  32'(k == last));
      chk({t, " busy"},       32'(busy),       32'(k != last));
      chk({t, " words_done"}, 32'(words_done), 32'(wd));
      if (rd) chk({t, " radr"}, 32'(dir ? ibus_radr : mem_radr), 32'(ra));
      if (wr) begin
        chk({t, " wadr"},  32'(dir ? mem_wadr : ibus_wadr),   32'(wa));
        chk({t, " wdata"}, 32'(dir ? mem_wdata : ibus_wdata), 32'(wdat));
      end
      if (k < last) tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    tick(); tick();

    // Reset state
    chk("rst cmd_ready", 32'(cmd_ready), 1);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst words_done", 32'(words_done), 0);
    chk_idle_bus("rst");
    chk("rst ibus_radr", 32'(ibus_radr), 0);
    chk("rst mem_radr", 32'(mem_radr), 0);
    chk("rst ibus_wadr", 32'(ibus_wadr), 0);
    chk("rst mem_wadr", 32'(mem_wadr), 0);
    chk("rst ibus_wdata", 32'(ibus_wdata), 0);
    chk("rst mem_wdata", 32'(mem_wdata), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Load: wdata 0xA100..0xA103 to ibus 0x0000..0x0003 on cycles 3..6
    run_cmd(1'b0, 14'h0100, 14'h0000, 4, 1'b0);
    chk("load words_done", 32'(words_done), 32'd4);

    // Unload: ibus 0x2000.. -> mem 0x0400.., data 0x7000..0x7002
    run_cmd(1'b1, 14'h2000, 14'h0400, 3, 1'b0);
    chk("unload words_done", 32'(words_done), 32'd3);

    // Zero length
    run_cmd(1'b0, 14'h0123, 14'h0456, 0, 1'b0);
    chk("zero words_done", 32'(words_done), 32'd0);

    // Address wrap on both sides
    run_cmd(1'b0, 14'h3FFE, 14'h3FFF, 4, 1'b0);

    // cmd_valid held through a len=2 transfer; the second command must be
    // taken only on the IDLE cycle N+4 with its own parameters.
    run_cmd(1'b0, 14'h0010, 14'h0200, 2, 1'b1);
    run_cmd(1'b1, 14'h0300, 14'h0020, 1, 1'b0);
    chk("chain words_done", 32'(words_done), 32'd1);

    // Reset at cycle 3 of a len=8 load
    cmd_dir   = 1'b0;
    cmd_src   = 14'h0040;
    cmd_dst   = 14'h0080;
    cmd_len   = 11'd8;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("pre-rst ibus_wen", 32'(ibus_wen), 1);
    chk("pre-rst mem_ren", 32'(mem_ren), 1);
    rst_n = 1'b0;
    #1;
    chk_idle_bus("midrst");
    chk("midrst cmd_ready", 32'(cmd_ready), 1);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst words_done", 32'(words_done), 0);
    chk("midrst ibus_wdata", 32'(ibus_wdata), 0);
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_idle_bus($sformatf("postrst c%0d", k));
      chk($sformatf("postrst c%0d cmd_ready", k), 32'(cmd_ready), 1);
      chk($sformatf("postrst c%0d done", k), 32'(done), 0);
      chk($sformatf("postrst c%0d words_done", k), 32'(words_done), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
